audio_pwm_sched: RTL and testbench



---
 rtl/audio_pwm_sched_pkg.sv | 17 +
 rtl/audio_sample_fifo.sv | 72 +++++++
 rtl/audio_pwm_sched.sv | 144 ++++++++++++++
 tb/tb_audio_pwm_sched.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pwm_sched_pkg.sv
// Shared types and helpers for the audio PWM scheduler.
// State encoding is exported on o_state, so keep the values stable.
package audio_pwm_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    // Offset-binary silence level for a given sample width.
    function automatic int unsigned midscale(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with flush and occupancy output.
// The head word is presented combinationally on dout.
module audio_sample_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  logic [DW-1:0]           din,
    output logic [DW-1:0]           dout,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          do_push, do_pop;

    assign full    = level_q == (AW+1)'(DEPTH);
    assign empty   = level_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign level   = level_q;

    // Pointer and occupancy update; flush wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Sample storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/audio_pwm_sched.sv
// Sample-rate scheduler and PWM sequencer for the mono audio pins.
// Option: AUDIO_PWM_SCHED_UNDERRUN_MUTE_EN loads silence on underrun.
module audio_pwm_sched
    import audio_pwm_sched_pkg::*;
#(
    parameter int SAMPLE_W   = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_enable,
    input  logic [DIV_W-1:0]             i_div,
    input  logic [SAMPLE_W-1:0]          i_sample,
    input  logic                         i_sample_valid,
    output logic                         o_sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level,
    output logic                         o_sample_tick,
    output logic                         o_underrun,
    input  logic                         i_clr_underrun,
    output logic                         o_pwm_audio,
    output logic                         o_sd_audio,
    output logic [1:0]                   o_state
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [SAMPLE_W-1:0] MID = SAMPLE_W'(midscale(SAMPLE_W));
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'((2**SAMPLE_W) - 1);
    localparam logic [LW-1:0] PRIME_LVL = LW'(FIFO_DEPTH / 2);

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]    div_lat_q, div_lat_d;
    logic [DIV_W-1:0]    eff_div;
    logic [SAMPLE_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [SAMPLE_W-1:0] active_q, active_d;
    logic [SAMPLE_W-1:0] pending_q, pending_d;
    logic                pwm_q, pwm_d;
    logic                underrun_q, underrun_d;

    logic                run, tick, push, pop, flush;
    logic                fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0] fifo_dout;
    logic [LW-1:0]       fifo_level;

    assign run     = state_q == ST_RUN;
    assign flush   = state_q == ST_FLUSH;
    assign eff_div = (div_lat_q < MIN_DIV) ? MIN_DIV : div_lat_q;
    assign tick    = run && (div_cnt_q == eff_div);
    assign push    = i_sample_valid && !fifo_full;
    assign pop     = tick && !fifo_empty;

    audio_sample_fifo #(
        .DW    (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (i_sample),
        .dout  (fifo_dout),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state logic for the run/prime/flush sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (i_enable) state_d = ST_PRIME;
            ST_PRIME: begin
                if (!i_enable) state_d = ST_IDLE;
                else if (fifo_level >= PRIME_LVL) state_d = ST_RUN;
            end
            ST_RUN:   if (!i_enable) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Divider, PWM frame, sample pipeline and underrun flag.
    always_comb begin
        div_cnt_d  = '0;
        div_lat_d  = i_div;
        pwm_cnt_d  = '0;
        pwm_d      = 1'b0;
        pending_d  = pending_q;
        active_d   = active_q;
        underrun_d = underrun_q;
        if (run) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
            div_lat_d = tick ? i_div : div_lat_q;
            pwm_cnt_d = pwm_cnt_q + 1'b1;
            pwm_d     = pwm_cnt_q < active_q;
        end
        if (pop) pending_d = fifo_dout;
`ifdef AUDIO_PWM_SCHED_UNDERRUN_MUTE_EN
        else if (tick) pending_d = MID;
`endif
        // Bypass so a pop on the last frame cycle lands next frame.
        if (run && (&pwm_cnt_q)) active_d = pending_d;
        if (flush) begin
            pending_d = MID;
            active_d  = MID;
        end
        if (i_clr_underrun) underrun_d = 1'b0;
        if (tick && fifo_empty) underrun_d = 1'b1;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            div_lat_q  <= '0;
            pwm_cnt_q  <= '0;
            pwm_q      <= 1'b0;
            active_q   <= MID;
            pending_q  <= MID;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            div_lat_q  <= div_lat_d;
            pwm_cnt_q  <= pwm_cnt_d;
            pwm_q      <= pwm_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_sample_ready = !fifo_full;
    assign o_fifo_level   = fifo_level;
    assign o_sample_tick  = tick;
    assign o_underrun     = underrun_q;
    assign o_pwm_audio    = pwm_q;
    assign o_sd_audio     = run;
    assign o_state        = state_q;

endmodule

// File: tb/tb_audio_pwm_sched.sv
// Self-checking bench for audio_pwm_sched: vector table, directed
// corner sequences and a randomized queue-based scoreboard.
module tb_audio_pwm_sched;

    localparam int SW    = 8;
    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int LW    = 5;
`ifdef AUDIO_PWM_SCHED_UNDERRUN_MUTE_EN
    localparam int HOLD_DUTY = 128;
`else
    localparam int HOLD_DUTY = 64;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          valid = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] div = '0;
    logic [SW-1:0] smp = '0;
    logic          ready, tick, underrun, pwm, sd;
    logic [LW-1:0] level;
    logic [1:0]    state;

    int checks = 0;
    int failures = 0;
    int n, hi;

    typedef struct {
        logic       en;
        logic       v;
        logic [7:0] s;
        int         rdy;
        int         lvl;
        int         st;
    } vec_t;
    vec_t tbl[8];

    always #5 clk = ~clk;

    audio_pwm_sched #(
        .SAMPLE_W   (SW),
        .FIFO_DEPTH (DEPTH),
        .DIV_W      (DW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_enable       (en),
        .i_div          (div),
        .i_sample       (smp),
        .i_sample_valid (valid),
        .o_sample_ready (ready),
        .o_fifo_level   (level),
        .o_sample_tick  (tick),
        .o_underrun     (underrun),
        .i_clr_underrun (clr),
        .o_pwm_audio    (pwm),
        .o_sd_audio     (sd),
        .o_state        (state)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        valid = 1'b0;
        clr = 1'b0;
        div = '0;
        smp = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Counts edges to the next visible tick; sums PWM over edges 301..556.
    task automatic wait_tick(input int limit, output int cnt, output int highs);
        cnt = 0;
        highs = 0;
        do begin
            step();
            cnt++;
            if (cnt > 300 && cnt <= 556) highs += int'(pwm);
        end while (!tick && cnt < limit);
        if (!tick) chk("tick_timeout", 0, 1);
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b0, 8'h00, 1, 0, 0};
        tbl[1] = '{1'b1, 1'b1, 8'h11, 1, 1, 1};
        tbl[2] = '{1'b1, 1'b1, 8'h22, 1, 2, 1};
        tbl[3] = '{1'b1, 1'b1, 8'h33, 1, 3, 1};
        tbl[4] = '{1'b1, 1'b0, 8'h00, 1, 3, 1};
        tbl[5] = '{1'b1, 1'b0, 8'h00, 1, 3, 1};
        tbl[6] = '{1'b0, 1'b0, 8'h00, 1, 3, 0};
        tbl[7] = '{1'b0, 1'b1, 8'h44, 1, 4, 0};

        // Reset state and idle/prime vector table.
        do_reset();
        chk("rst_ready", ready, 1);
        chk("rst_level", level, 0);
        chk("rst_state", state, 0);
        chk("rst_pwm", pwm, 0);
        chk("rst_sd", sd, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_tick", tick, 0);
        for (int i = 0; i < 8; i++) begin
            en = tbl[i].en;
            valid = tbl[i].v;
            smp = tbl[i].s;
            step();
            chk($sformatf("tbl%0d_ready", i), ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_level", i), level, tbl[i].lvl);
            chk($sformatf("tbl%0d_state", i), state, tbl[i].st);
            chk($sformatf("tbl%0d_sd", i), sd, 0);
        end

        // Full FIFO back-pressure, pop-while-full, then flush.
        do_reset();
        valid = 1'b1;
        smp = 8'hAA;
        repeat (16) step();
        chk("full_level", level, 16);
        chk("full_ready", ready, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("full_hold%0d", i), level, 16);
        end
        en = 1'b1;
        n = 0;
        while (!tick && n < 600) begin
            step();
            n++;
        end
        chk("fill_tick_seen", tick, 1);
        chk("fill_tick_ready", ready, 0);
        chk("fill_tick_level", level, 16);
        step();
        chk("pop_full_level", level, 15);
        chk("pop_full_ready", ready, 1);
        step();
        chk("refill_level", level, 16);
        en = 1'b0;
        valid = 1'b0;
        step();
        chk("flush_state", state, 3);
        step();
        chk("post_flush_state", state, 0);
        chk("post_flush_level", level, 0);
        chk("post_flush_pwm", pwm, 0);
        chk("post_flush_sd", sd, 0);

        // Run at i_div=999, then shrink below the minimum, then underrun.
        do_reset();
        div = 16'd999;
        en = 1'b1;
        valid = 1'b1;
        smp = 8'h40;
        repeat (8) step();
        valid = 1'b0;
        n = 0;
        while (state != 2'd2 && n < 50) begin
            step();
            n++;
        end
        chk("run_entry", state, 2);
        chk("run_sd", sd, 1);
        wait_tick(2000, n, hi);
        for (int t = 1; t <= 9; t++) begin
            chk($sformatf("tick%0d_level", t), level, t <= 8 ? 9 - t : 0);
            chk($sformatf("tick%0d_underrun", t), underrun, 0);
            if (t == 3) div = 16'd10;
            if (t == 9) begin
                clr = 1'b1;
                step();
                clr = 1'b0;
                chk("set_beats_clr", underrun, 1);
            end else begin
                wait_tick(2000, n, hi);
                chk($sformatf("tick%0d_period", t), n, t < 3 ? 1000 : 256);
                if (t < 3) chk($sformatf("duty64_%0d", t), hi, 64);
            end
        end
        repeat (300) step();
        hi = 0;
        repeat (256) begin
            step();
            hi += int'(pwm);
        end
        chk("underrun_duty", hi, HOLD_DUTY);
        chk("pre_rst_sd", sd, 1);
        chk("pre_rst_underrun", underrun, 1);

        // Asynchronous reset between clock edges.
        #3 rst = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_level", level, 0);
        chk("arst_ready", ready, 1);
        chk("arst_sd", sd, 0);
        chk("arst_pwm", pwm, 0);
        chk("arst_underrun", underrun, 0);
        chk("arst_tick", tick, 0);
        step();
        rst = 1'b0;

        // Randomized pushes against a queue scoreboard.
        for (int it = 0; it < 4; it++) begin
            int d, p, pct, phase, k, urun;
            logic [7:0] q[$];
            d = $urandom_range(0, 600);
            p = (d < 255 ? 255 : d) + 1;
            pct = (it == 0) ? 50 : $urandom_range(1, 6);
            do_reset();
            div = DW'(d);
            en = 1'b1;
            phase = 0;
            k = 0;
            urun = 0;
            q.delete();
            for (int c = 0; c < 2000; c++) begin
                int lv;
                bit tk, pu;
                valid = ($urandom_range(0, 99) < pct);
                smp = 8'($urandom);
                lv = q.size();
                tk = (phase == 2) && (k % p == p - 1);
                pu = valid && (lv < DEPTH);
                if (tk && lv > 0) void'(q.pop_front());
                if (tk && lv == 0) urun = 1;
                if (pu) q.push_back(smp);
                if (phase == 2) k++;
                else if (phase == 1 && lv >= DEPTH / 2) begin
                    phase = 2;
                    k = 0;
                end else if (phase == 0) phase = 1;
                step();
                chk("rnd_level", level, q.size());
                chk("rnd_state", state, phase);
                chk("rnd_tick", tick, (phase == 2) && (k % p == p - 1));
                chk("rnd_underrun", underrun, urun);
                chk("rnd_sd", sd, phase == 2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
